// File: rtl/tl_ram_slave.sv
// TileLink-UL RAM slave: one outstanding request, 64-bit words.
// IDLE accepts, ACCESS touches the RAM, RESP holds the D beat.
module tl_ram_slave #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [5:0]  SINK_ID    = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  input  logic        a_corrupt,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic [5:0]  d_sink,
  output logic        d_denied,
  output logic [63:0] d_data,
  output logic        d_corrupt,
  output logic        d_valid,
  input  logic        d_ready
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic   a_ready_q, a_ready_d;

  logic [2:0]  op_q;
  logic [2:0]  size_q;
  logic [3:0]  src_q;
  logic [63:0] addr_q;
  logic [7:0]  mask_q;
  logic [63:0] data_q;
  logic        corrupt_q;

  logic [2:0]  d_opcode_q;
  logic        d_denied_q;
  logic [63:0] d_data_q;
  logic        d_corrupt_q;

  logic [63:0] mem [WORDS];

  logic                  accept;
  logic                  is_put;
  logic                  is_get;
  logic                  denied;
  logic [2:0]            amask;
  logic [DEPTH_LOG2-1:0] idx;
  logic [63:0]           rdata;

  logic unused_param;
  assign unused_param = ^a_param;

  assign accept = (state_q == IDLE) && a_valid && a_ready_q;

  always_comb begin
    state_d   = state_q;
    a_ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        a_ready_d = 1'b1;
        if (accept) begin
          state_d   = ACCESS;
          a_ready_d = 1'b0;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (d_ready) begin
          state_d   = IDLE;
          a_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_ready_q <= a_ready_d;
    end
  end

  // Low address bits that must be zero for the requested size
  always_comb begin
    amask = 3'b111;
    case (size_q)
      3'd0:    amask = 3'b000;
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end

  assign is_put = (op_q == 3'd0) || (op_q == 3'd1);
  assign is_get = (op_q == 3'd4);
  assign idx    = addr_q[DEPTH_LOG2+2:3];
  assign rdata  = mem[idx];

  assign denied = (|addr_q[63:DEPTH_LOG2+3])
                | !(is_put || is_get)
                | (size_q > 3'd3)
                | (|(addr_q[2:0] & amask))
                | (is_put && corrupt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 3'd0;
      size_q      <= 3'd0;
      src_q       <= 4'd0;
      addr_q      <= 64'd0;
      mask_q      <= 8'd0;
      data_q      <= 64'd0;
      corrupt_q   <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_denied_q  <= 1'b0;
      d_data_q    <= 64'd0;
      d_corrupt_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= a_opcode;
        size_q    <= a_size;
        src_q     <= a_source;
        addr_q    <= a_address;
        mask_q    <= a_mask;
        data_q    <= a_data;
        corrupt_q <= a_corrupt;
      end
      if (state_q == ACCESS) begin
        d_opcode_q  <= is_get ? 3'd1 : 3'd0;
        d_denied_q  <= denied;
        d_data_q    <= (is_get && !denied) ? rdata : 64'd0;
        d_corrupt_q <= denied && is_get;
      end
    end
  end

  // RAM has no reset; an async reset drops state_q so no write fires
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && is_put && !denied) begin
      for (int b = 0; b < 8; b++) begin
        if (mask_q[b]) mem[idx][b*8 +: 8] <= data_q[b*8 +: 8];
      end
    end
  end

  assign a_ready   = a_ready_q;
  assign d_valid   = (state_q == RESP);
  assign d_opcode  = d_opcode_q;
  assign d_param   = 2'd0;
  assign d_size    = size_q;
  assign d_source  = src_q;
  assign d_sink    = SINK_ID;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign d_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Directed bench for tl_ram_slave: puts, gets, denials,
// backpressure, throughput and reset in flight.
module tb_tl_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [5:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;
  logic        d_valid;
  logic        d_ready;

  int checks = 0;
  int failures = 0;

  logic [2:0]  r_opcode;
  logic [2:0]  r_size;
  logic [3:0]  r_source;
  logic        r_denied;
  logic [63:0] r_data;
  logic        r_corrupt;

  tl_ram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt), .a_valid(a_valid),
    .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] sz,
                     input logic [3:0] src, input logic [63:0] addr,
                     input logic [7:0] mask, input logic [63:0] data,
                     input logic cor);
    int n;
    a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    a_mask = mask; a_data = data; a_corrupt = cor;
    a_valid = 1'b1; d_ready = 1'b1;
    n = 0;
    while (!a_ready && n < 20) begin
      tick();
      n++;
    end
    chk("a_ready_wait", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    chk("access_a_ready", {63'd0, a_ready}, 64'd0);
    chk("access_d_valid", {63'd0, d_valid}, 64'd0);
    tick();
    chk("resp_d_valid", {63'd0, d_valid}, 64'd1);
    chk("resp_d_param", {62'd0, d_param}, 64'd0);
    chk("resp_d_sink", {58'd0, d_sink}, 64'd0);
    r_opcode = d_opcode; r_size = d_size; r_source = d_source;
    r_denied = d_denied; r_data = d_data; r_corrupt = d_corrupt;
    tick();
    chk("idle_a_ready", {63'd0, a_ready}, 64'd1);
    chk("idle_d_valid", {63'd0, d_valid}, 64'd0);
  endtask

  initial begin
    int acc [$];
    int first_dv;
    logic [63:0] snap;

    rst_n = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0;
    a_source = 4'd0; a_address = 64'd0; a_mask = 8'd0; a_data = 64'd0;
    a_corrupt = 1'b0; a_valid = 1'b0; d_ready = 1'b1;

    tick();
    tick();
    chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
    chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_d_opcode", {61'd0, d_opcode}, 64'd0);
    chk("rst_d_denied", {63'd0, d_denied}, 64'd0);
    chk("rst_d_sink", {58'd0, d_sink}, 64'd0);
    rst_n = 1'b1;
    chk("rel_a_ready_lo", {63'd0, a_ready}, 64'd0);
    tick();
    chk("rel_a_ready_hi", {63'd0, a_ready}, 64'd1);

    // PutFullData then Get
    req(3'd0, 3'd3, 4'd3, 64'h18, 8'hFF, 64'h1122334455667788, 1'b0);
    chk("put_opcode", {61'd0, r_opcode}, 64'd0);
    chk("put_source", {60'd0, r_source}, 64'd3);
    chk("put_denied", {63'd0, r_denied}, 64'd0);
    chk("put_data", r_data, 64'd0);
    chk("put_size", {61'd0, r_size}, 64'd3);
    req(3'd4, 3'd3, 4'd5, 64'h18, 8'hFF, 64'd0, 1'b0);
    chk("get_opcode", {61'd0, r_opcode}, 64'd1);
    chk("get_source", {60'd0, r_source}, 64'd5);
    chk("get_data", r_data, 64'h1122334455667788);
    chk("get_corrupt", {63'd0, r_corrupt}, 64'd0);

    // PutPartialData low four lanes
    req(3'd1, 3'd3, 4'd2, 64'h18, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    chk("pp_denied", {63'd0, r_denied}, 64'd0);
    req(3'd4, 3'd3, 4'd2, 64'h18, 8'hFF, 64'd0, 1'b0);
    chk("pp_get_data", r_data, 64'h11223344AAAAAAAA);

    // Backpressure with a second request waiting
    a_opcode = 3'd4; a_size = 3'd3; a_source = 4'd9;
    a_address = 64'h18; a_mask = 8'hFF; a_corrupt = 1'b0;
    a_valid = 1'b1; d_ready = 1'b0;
    tick();
    a_source = 4'd7;
    chk("bp_acc_a_ready", {63'd0, a_ready}, 64'd0);
    tick();
    chk("bp_d_valid", {63'd0, d_valid}, 64'd1);
    chk("bp_source", {60'd0, d_source}, 64'd9);
    snap = d_data;
    chk("bp_data", snap, 64'h11223344AAAAAAAA);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", {63'd0, d_valid}, 64'd1);
      chk("bp_hold_data", d_data, 64'h11223344AAAAAAAA);
      chk("bp_hold_source", {60'd0, d_source}, 64'd9);
      chk("bp_hold_a_ready", {63'd0, a_ready}, 64'd0);
    end
    d_ready = 1'b1;
    tick();
    chk("bp_hs_d_valid", {63'd0, d_valid}, 64'd0);
    chk("bp_hs_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    chk("bp_2nd_acc", {63'd0, a_ready}, 64'd0);
    tick();
    chk("bp_2nd_valid", {63'd0, d_valid}, 64'd1);
    chk("bp_2nd_source", {60'd0, d_source}, 64'd7);
    tick();

    // Denials
    req(3'd4, 3'd3, 4'd1, 64'h2000, 8'hFF, 64'd0, 1'b0);
    chk("dn_hi_denied", {63'd0, r_denied}, 64'd1);
    chk("dn_hi_corrupt", {63'd0, r_corrupt}, 64'd1);
    chk("dn_hi_data", r_data, 64'd0);
    req(3'd4, 3'd4, 4'd1, 64'h18, 8'hFF, 64'd0, 1'b0);
    chk("dn_size_denied", {63'd0, r_denied}, 64'd1);
    req(3'd4, 3'd2, 4'd1, 64'h1A, 8'hFF, 64'd0, 1'b0);
    chk("dn_align_denied", {63'd0, r_denied}, 64'd1);
    req(3'd2, 3'd3, 4'd1, 64'h18, 8'hFF, 64'd0, 1'b0);
    chk("dn_op_denied", {63'd0, r_denied}, 64'd1);
    req(3'd0, 3'd3, 4'd4, 64'h18, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b1);
    chk("dn_cor_denied", {63'd0, r_denied}, 64'd1);
    chk("dn_cor_corrupt", {63'd0, r_corrupt}, 64'd0);
    chk("dn_cor_opcode", {61'd0, r_opcode}, 64'd0);
    req(3'd4, 3'd2, 4'd1, 64'h1C, 8'hF0, 64'd0, 1'b0);
    chk("dn_after_denied", {63'd0, r_denied}, 64'd0);
    chk("dn_after_data", r_data, 64'h11223344AAAAAAAA);

    // Throughput: a_valid and d_ready held high
    a_opcode = 3'd4; a_size = 3'd3; a_address = 64'h18;
    a_valid = 1'b1; d_ready = 1'b1;
    first_dv = -1;
    for (int i = 0; i < 12; i++) begin
      logic took;
      took = a_ready;
      tick();
      if (took) acc.push_back(i);
      if (d_valid && first_dv < 0) first_dv = i;
    end
    a_valid = 1'b0;
    chk("tp_count", 64'(acc.size()), 64'd4);
    if (acc.size() == 4) begin
      chk("tp_first", 64'(acc[0]), 64'd0);
      chk("tp_gap1", 64'(acc[1] - acc[0]), 64'd3);
      chk("tp_gap2", 64'(acc[2] - acc[1]), 64'd3);
      chk("tp_gap3", 64'(acc[3] - acc[2]), 64'd3);
      chk("tp_first_dv", 64'(first_dv), 64'(acc[0] + 1));
    end
    tick();

    // Reset while in RESP
    a_opcode = 3'd4; a_address = 64'h18; a_valid = 1'b1; d_ready = 1'b0;
    chk("rr_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    tick();
    chk("rr_d_valid_pre", {63'd0, d_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_d_valid_rst", {63'd0, d_valid}, 64'd0);
    chk("rr_a_ready_rst", {63'd0, a_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    d_ready = 1'b1;
    chk("rr_a_ready_rel", {63'd0, a_ready}, 64'd0);
    tick();
    chk("rr_a_ready_up", {63'd0, a_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_no_spurious", {63'd0, d_valid}, 64'd0);
    end

    // Reset during ACCESS blocks the write
    a_opcode = 3'd0; a_size = 3'd3; a_address = 64'h18; a_mask = 8'hFF;
    a_data = 64'h0123456789ABCDEF; a_corrupt = 1'b0; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    req(3'd4, 3'd3, 4'd6, 64'h18, 8'hFF, 64'd0, 1'b0);
    chk("ra_no_write", r_data, 64'h11223344AAAAAAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_ram_slave.md
TL_RAM_SLAVE -- requirements
Module: tl_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning the RAM holds 2^DEPTH_LOG2 words of 64 bits each.
REQ-002 SHALL have parameter SINK_ID, default 6'd0, meaning the constant driven on d_sink.
REQ-003 SHALL have ports, one per line, as name, direction, width, meaning:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- a_opcode  in  3  request opcode: 0 PutFullData, 1 PutPartialData, 4 Get
- a_param  in  3  ignored
- a_size  in  3  log2 of the byte count
- a_source  in  4  requester ID
- a_address  in  64  byte address, local to the chip (crossbar already translated it)
- a_mask  in  8  byte lane enables
- a_data  in  64  write data
- a_corrupt  in  1  write data corrupt
- a_valid  in  1  request valid
- a_ready  out  1  request accepted
- d_opcode  out  3  response opcode: 0 AccessAck, 1 AccessAckData
- d_param  out  2  always 0
- d_size  out  3  echo of captured a_size
- d_source  out  4  echo of captured a_source
- d_sink  out  6  SINK_ID
- d_denied  out  1  request rejected
- d_data  out  64  read data
- d_corrupt  out  1  read data invalid
- d_valid  out  1  response valid
- d_ready  in  1  response accepted

Function
REQ-004 SHALL implement a 3-state FSM: IDLE, ACCESS, RESP; only one request is outstanding at a time.
REQ-005 In IDLE, a_ready SHALL be 1; when a_valid&a_ready is true at a clock edge, the block SHALL capture all a_* fields and enter ACCESS.
REQ-006 a_ready SHALL be 0 in ACCESS and RESP; a_* inputs SHALL be ignored there.
REQ-007 ACCESS SHALL last exactly 1 cycle:
- Get: the RAM word is read.
- Put: the RAM word is written.
- The FSM then enters RESP.
REQ-008 In RESP, d_valid SHALL be 1 and all d_* fields SHALL be held stable until d_valid&d_ready.
REQ-009 On d_valid&d_ready the FSM SHALL return to IDLE, with a_ready=1 in the next cycle.
REQ-010 Timing:
- Accept at edge N gives d_valid=1 from cycle N+2.
- With d_ready held at 1, the minimum request-to-request interval SHALL be 3 cycles.
REQ-011 Word index SHALL be a_address[DEPTH_LOG2+2:3].
REQ-012 A request SHALL be denied if any of the following holds:
- a_address[63:DEPTH_LOG2+3] is nonzero;
- a_opcode is not in {0,1,4};
- a_size > 3;
- the address is misaligned to 2^a_size;
- it is a Put with a_corrupt=1.
REQ-013 A denied request SHALL leave the RAM unmodified.
REQ-014 Put writes SHALL update only the byte lanes whose a_mask bit is 1.
REQ-015 For PutFullData, a_mask SHALL NOT be checked against a_size; the mask is applied as given.
REQ-016 Response encoding:
- Put: d_opcode=0, d_data=0, d_corrupt=0.
- Get: d_opcode=1, d_data = the full 64-bit RAM word, with no lane masking.
REQ-017 For a denied request, d_denied SHALL be 1, d_data SHALL be 0, and d_corrupt SHALL be 1 for Get and 0 for Put.
REQ-018 The response SHALL reflect RAM contents before any later request; there is no read/write overlap because requests are serialized.
REQ-019 d_param SHALL be 0 and d_sink SHALL be SINK_ID whenever d_valid=1.
REQ-020 d_valid SHALL never be asserted without a preceding accepted request.

Reset
REQ-021 While rst_n=0, outputs SHALL be:
- FSM in IDLE;
- a_ready=0, d_valid=0;
- every other d_* output at 0, except d_sink=SINK_ID.
REQ-022 a_ready SHALL be a register that becomes 1 at the first rising clk edge after rst_n deasserts.
REQ-023 RAM contents SHALL NOT be reset.
REQ-024 Reset asserted mid-operation SHALL behave as follows:
- Any pending response is discarded.
- If reset asserts before the ACCESS-state clock edge, no write occurs.
- A write already committed at that edge is retained.

Verification
REQ-025 Put then Get:
- PutFullData addr 0x18, mask 0xFF, data 0x1122334455667788, source 3, gives AccessAck with d_source=3 and d_denied=0.
- A following Get of addr 0x18, size 3, returns AccessAckData with d_data=0x1122334455667788.
REQ-026 Partial write: after REQ-025, PutPartialData addr 0x18, mask 0x0F, data 0xAAAAAAAAAAAAAAAA, then a Get, returns d_data=0x11223344AAAAAAAA.
REQ-027 Backpressure:
- Hold d_ready=0 for 5 cycles after d_valid rises.
- d_* SHALL stay stable and a_ready SHALL stay 0 throughout.
- A new a_valid offered during this window SHALL NOT be accepted until the cycle after the D handshake.
REQ-028 Denial cases (DEPTH_LOG2=10):
- Get addr 0x2000 gives d_denied=1, d_corrupt=1, d_data=0.
- Get size 4 gives d_denied=1.
- Put with a_corrupt=1 to addr 0x18 gives d_denied=1, and a subsequent Get of 0x18 returns unchanged data.
REQ-029 Throughput: back-to-back Gets with a_valid and d_ready held at 1 SHALL be accepted every 3 cycles, with d_valid first high 2 cycles after the first accept.
REQ-030 Reset in flight: assert rst_n=0 while in RESP, release it, and check d_valid=0, a_ready=0 then 1 one edge later, and no spurious response.
